gear_ecu: RTL and testbench

- Sequential error-detection and correction stage placed directly downstream of the GeAr approximate adder.
- Accepts one operand pair per transaction and computes the GeAr approximate sum through an embedded GeAr instance.
- When correction is enabled, walks the upper sub-adder segments one per cycle and produces the exact sum, per-segment error flags and a saturating error counter.
- Used to trade latency for accuracy at run time.

---
 rtl/gear_ecu_pkg.sv | 26 ++
 rtl/gear_ecu_gear.sv | 33 +++
 rtl/gear_ecu.sv | 160 ++++++++++++++++
 tb/tb_gear_ecu.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gear_ecu_pkg.sv
// Shared definitions for the GeAr error-correction stage: FSM encoding and
// segment geometry helpers used by both the GeAr block and the ECU.
package gear_ecu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DETECT  = 2'd1,
        ST_CORRECT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Number of sub-adders in a GeAr(N, R, P) adder.
    function automatic int num_sub(input int n, input int r, input int p);
        return (n - r - p) / r + 1;
    endfunction

    function automatic bit geom_ok(input int n, input int r, input int p);
        return (r > 0) && ((n - r - p) % r == 0) && (num_sub(n, r, p) >= 2);
    endfunction

    // Lowest result bit (0-based) of segment j, j = 2..K.
    function automatic int seg_lo(input int j, input int r, input int p);
        return (j - 1) * r + p;
    endfunction

endpackage

// File: rtl/gear_ecu_gear.sv
// GeAr(N, R, P) approximate adder: the first sub-adder is exact, each later
// sub-adder predicts its carry-in from P overlap bits and keeps its top R bits.
module gear_ecu_gear
    import gear_ecu_pkg::*;
#(
    parameter int N = 16,
    parameter int R = 2,
    parameter int P = 6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int K = num_sub(N, R, P);

    assign sum[R+P-1:0] = a[R+P-1:0] + b[R+P-1:0] + {{(R+P-1){1'b0}}, cin};

    for (genvar j = 2; j <= K; j++) begin : g_sub
        localparam int LO = (j - 1) * R;
        localparam int OL = seg_lo(j, R, P);
        if (j < K) begin : g_mid
            assign sum[OL +: R] = R'(({1'b0, a[LO +: R+P]} + {1'b0, b[LO +: R+P]}) >> P);
        end else begin : g_last
            // Only the last sub-adder's carry leaves the adder.
            assign {cout, sum[OL +: R]} =
                (R+1)'(({1'b0, a[LO +: R+P]} + {1'b0, b[LO +: R+P]}) >> P);
        end
    end

endmodule

// File: rtl/gear_ecu.sv
// Sequential error detection/correction behind a GeAr adder: registers the
// approximate sum, then optionally ripples the exact carry one segment per cycle.
module gear_ecu
    import gear_ecu_pkg::*;
#(
    parameter int N     = 16,
    parameter int R     = 2,
    parameter int P     = 6,
    parameter int CNT_W = 16,
    localparam int K    = num_sub(N, R, P)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CORRECT_EN,
    input  logic             CNT_CLR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [N-1:0]     SUM,
    output logic             COUT,
    output logic [N-1:0]     APPROX_SUM,
    output logic [K-2:0]     ERR_FLAGS,
    output logic             ERROR,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [1:0]       DBG_STATE
);

    localparam int JW = $clog2(K + 1);

    if (!geom_ok(N, R, P)) begin : g_bad_geometry
        $error("gear_ecu: N-R-P must be a multiple of R and give at least two sub-adders");
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    state_t             state_q, state_d;
    logic [N-1:0]       a_q, b_q, sum_q, approx_q;
    logic               cin_q, mode_q, carry_q, cout_q;
    logic [JW-1:0]      seg_j;
    logic [K-2:0]       flags_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [N-1:0]       gear_sum;
    logic               gear_cout, seg1_carry, seg_c;
    logic [R-1:0]       a_seg, b_seg, ap_seg, seg_s;

    gear_ecu_gear #(.N(N), .R(R), .P(P)) u_gear (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .sum  (gear_sum),
        .cout (gear_cout)
    );

    assign seg1_carry = 1'(({1'b0, a_q[R+P-1:0]} + {1'b0, b_q[R+P-1:0]}
                            + {{(R+P){1'b0}}, cin_q}) >> (R+P));

    always_comb begin
        a_seg  = '0;
        b_seg  = '0;
        ap_seg = '0;
        for (int j = 2; j <= K; j++) begin
            if (seg_j == JW'(j)) begin
                a_seg  = a_q[seg_lo(j, R, P) +: R];
                b_seg  = b_q[seg_lo(j, R, P) +: R];
                ap_seg = approx_q[seg_lo(j, R, P) +: R];
            end
        end
        {seg_c, seg_s} = {1'b0, a_seg} + {1'b0, b_seg} + {{R{1'b0}}, carry_q};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (state_q)
            ST_IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) state_d = ST_DETECT;
            end
            ST_DETECT:  state_d = mode_q ? ST_CORRECT : ST_DONE;
            ST_CORRECT: if (seg_j == JW'(K)) state_d = ST_DONE;
            ST_DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            mode_q   <= 1'b0;
            sum_q    <= '0;
            approx_q <= '0;
            cout_q   <= 1'b0;
            carry_q  <= 1'b0;
            flags_q  <= '0;
            seg_j    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (IN_VALID) begin
                    a_q    <= A;
                    b_q    <= B;
                    cin_q  <= CIN;
                    mode_q <= CORRECT_EN;
                end
                ST_DETECT: begin
                    approx_q <= gear_sum;
                    sum_q    <= gear_sum;
                    cout_q   <= gear_cout;
                    carry_q  <= seg1_carry;
                    flags_q  <= '0;
                    seg_j    <= JW'(2);
                end
                ST_CORRECT: begin
                    // Overwrite one segment with its exact value and flag any difference.
                    for (int j = 2; j <= K; j++) begin
                        if (seg_j == JW'(j)) begin
                            sum_q[seg_lo(j, R, P) +: R] <= seg_s;
                            flags_q[j-2]                <= (seg_s != ap_seg);
                        end
                    end
                    carry_q <= seg_c;
                    seg_j   <= seg_j + JW'(1);
                    if (seg_j == JW'(K)) cout_q <= seg_c;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            err_cnt_q <= '0;
        else if (CNT_CLR)
            err_cnt_q <= '0;
        else if (state_q == ST_DONE && OUT_READY && ERROR && err_cnt_q != '1)
            err_cnt_q <= err_cnt_q + CNT_W'(1);
    end

    assign SUM        = sum_q;
    assign COUT       = cout_q;
    assign APPROX_SUM = approx_q;
    assign ERR_FLAGS  = flags_q;
    assign ERROR      = |flags_q;
    assign ERR_CNT    = err_cnt_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_gear_ecu.sv
// Bench for gear_ecu: directed literal cases plus randomized traffic checked every
// cycle against an arithmetic reference model of GeAr and exact addition.
module tb_gear_ecu;

    localparam int N  = 16;
    localparam int R  = 2;
    localparam int P  = 6;
    localparam int K  = 5;
    localparam int CW = 5;
    localparam int EW = N + 1 + N + (K - 1) + 1;

    logic          CLK = 1'b0, RST = 1'b1;
    logic          CORRECT_EN = 1'b0, CNT_CLR = 1'b0, IN_VALID = 1'b0, CIN = 1'b0;
    logic          OUT_READY = 1'b0;
    logic [N-1:0]  A = '0, B = '0;
    logic          IN_READY, OUT_VALID, COUT, ERROR;
    logic [N-1:0]  SUM, APPROX_SUM;
    logic [K-2:0]  ERR_FLAGS;
    logic [CW-1:0] ERR_CNT;
    logic [1:0]    DBG_STATE;

    int n_cmp = 0, n_fail = 0, cyc = 0;

    gear_ecu #(.N(N), .R(R), .P(P), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .CORRECT_EN(CORRECT_EN), .CNT_CLR(CNT_CLR),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .A(A), .B(B), .CIN(CIN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .SUM(SUM), .COUT(COUT),
        .APPROX_SUM(APPROX_SUM), .ERR_FLAGS(ERR_FLAGS), .ERROR(ERROR),
        .ERR_CNT(ERR_CNT), .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: actual=timeout required=event (t=%0t)", nm, $time);
    endtask

    // Result layout: {sum, cout, approx_sum, err_flags, error}
    function automatic logic [EW-1:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                                 input logic cin, input logic mode);
        longint ex, ap, t, lowm, rm;
        logic acout;
        logic [K-2:0] fl;
        lowm  = (longint'(1) << (R + P)) - 1;
        rm    = (longint'(1) << R) - 1;
        ex    = longint'(a) + longint'(b) + longint'(cin);
        t     = (longint'(a) & lowm) + (longint'(b) & lowm) + longint'(cin);
        ap    = t & lowm;
        acout = 1'b0;
        for (int j = 2; j <= K; j++) begin
            t  = ((longint'(a) >> ((j - 1) * R)) & lowm) + ((longint'(b) >> ((j - 1) * R)) & lowm);
            ap = ap | (((t >> P) & rm) << ((j - 1) * R + P));
            if (j == K) acout = t[R+P];
        end
        for (int j = 2; j <= K; j++)
            fl[j-2] = ((ex >> ((j - 1) * R + P)) & rm) != ((ap >> ((j - 1) * R + P)) & rm);
        if (mode) return {ex[N-1:0], ex[N], ap[N-1:0], fl, |fl};
        else      return {ap[N-1:0], acout, ap[N-1:0], {(K-1){1'b0}}, 1'b0};
    endfunction

    // ---------------- reference model / scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    bit            m_busy = 1'b0, m_valid = 1'b0;
    int            m_wait = 0;
    logic [CW-1:0] m_cnt = '0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            exp_q.delete();
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_wait  <= 0;
            m_cnt   <= '0;
        end else begin
            if (CNT_CLR)
                m_cnt <= '0;
            else if (m_valid && OUT_READY && exp_q.size() > 0 && exp_q[0][0] && m_cnt != '1)
                m_cnt <= m_cnt + 1'b1;
            if (m_valid && OUT_READY) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_busy  <= 1'b0;
                m_valid <= 1'b0;
            end else if (m_busy && !m_valid) begin
                m_wait <= m_wait - 1;
                if (m_wait == 1) m_valid <= 1'b1;
            end else if (!m_busy && IN_VALID) begin
                exp_q.push_back(ref_result(A, B, CIN, CORRECT_EN));
                m_busy <= 1'b1;
                m_wait <= CORRECT_EN ? K : 1;
            end
        end
    end

    always @(negedge CLK) begin
        logic [EW-1:0] e;
        chk("in_ready", IN_READY, !m_busy);
        chk("out_valid", OUT_VALID, m_valid);
        chk("err_cnt", ERR_CNT, m_cnt);
        if (m_valid && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("sum", SUM, e[EW-1 -: N]);
            chk("cout", COUT, e[N+K]);
            chk("approx_sum", APPROX_SUM, e[N+K-1 -: N]);
            chk("err_flags", ERR_FLAGS, e[K-1:1]);
            chk("error", ERROR, e[0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_txn(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                           input logic mode, input int hold, input bit clr_at_hs,
                           output logic [N-1:0] s, output logic [N-1:0] ap, output logic c,
                           output logic [K-2:0] f, output logic e, output int lat);
        int t, t0;
        @(negedge CLK);
        t = 0;
        while (!IN_READY && t < 50) begin
            CORRECT_EN = 1'($urandom);
            @(negedge CLK);
            t++;
        end
        if (!IN_READY) tmo("in_ready_wait");
        A = a; B = b; CIN = cin; CORRECT_EN = mode; IN_VALID = 1'b1;
        t0 = cyc;
        @(negedge CLK);
        IN_VALID = 1'b0;
        A = N'($urandom); B = N'($urandom); CIN = 1'($urandom); CORRECT_EN = 1'($urandom);
        t = 0;
        while (!OUT_VALID && t < 50) begin
            @(negedge CLK);
            CORRECT_EN = 1'($urandom);
            t++;
        end
        if (!OUT_VALID) tmo("out_valid_wait");
        lat = cyc - t0;
        s = SUM; ap = APPROX_SUM; c = COUT; f = ERR_FLAGS; e = ERROR;
        repeat (hold) @(negedge CLK);
        OUT_READY = 1'b1;
        CNT_CLR   = clr_at_hs;
        @(negedge CLK);
        OUT_READY = 1'b0;
        CNT_CLR   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] s, ap, ra, rb;
        logic c, e;
        logic [K-2:0] f;
        int lat;

        #1;
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_sum", SUM, 0);
        chk("rst_approx", APPROX_SUM, 0);
        chk("rst_cout", COUT, 0);
        chk("rst_flags", ERR_FLAGS, 0);
        chk("rst_error", ERROR, 0);
        chk("rst_cnt", ERR_CNT, 0);
        chk("rst_state", DBG_STATE, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        run_txn(16'h00FF, 16'h0001, 1'b0, 1'b1, 0, 1'b0, s, ap, c, f, e, lat);
        chk("t1_approx", ap, 16'h0000);
        chk("t1_sum", s, 16'h0100);
        chk("t1_cout", c, 0);
        chk("t1_flags", f, 4'b0001);
        chk("t1_error", e, 1);
        chk("t1_latency", lat, 6);
        chk("t1_cnt", ERR_CNT, 1);

        run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b1, 0, 1'b0, s, ap, c, f, e, lat);
        chk("t2_approx", ap, 16'hFF00);
        chk("t2_sum", s, 16'h0000);
        chk("t2_cout", c, 1);
        chk("t2_flags", f, 4'b1111);
        chk("t2_cnt", ERR_CNT, 2);

        run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, s, ap, c, f, e, lat);
        chk("t3_sum", s, 16'hFF00);
        chk("t3_cout", c, 0);
        chk("t3_flags", f, 0);
        chk("t3_latency", lat, 2);
        chk("t3_cnt", ERR_CNT, 2);

        run_txn(16'h1234, 16'h4321, 1'b0, 1'b1, 5, 1'b0, s, ap, c, f, e, lat);
        chk("t4_sum", s, 16'h5555);
        chk("t4_error", e, 0);
        chk("t4_sum_held", SUM, 16'h5555);

        // Abort during the second correction cycle.
        @(negedge CLK);
        A = 16'h00FF; B = 16'h0001; CIN = 1'b0; CORRECT_EN = 1'b1; IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("abort_out_valid", OUT_VALID, 0);
        chk("abort_in_ready", IN_READY, 1);
        chk("abort_sum", SUM, 0);
        chk("abort_approx", APPROX_SUM, 0);
        chk("abort_flags", ERR_FLAGS, 0);
        chk("abort_cnt", ERR_CNT, 0);
        @(negedge CLK);
        RST = 1'b0;
        run_txn(16'h00FF, 16'h0001, 1'b0, 1'b1, 0, 1'b0, s, ap, c, f, e, lat);
        chk("t6_sum", s, 16'h0100);
        chk("t6_cnt", ERR_CNT, 1);

        for (int i = 0; i < 35; i++)
            run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b1, 0, 1'b0, s, ap, c, f, e, lat);
        chk("sat_cnt", ERR_CNT, 5'h1F);
        run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b1, 0, 1'b1, s, ap, c, f, e, lat);
        chk("clr_prio_cnt", ERR_CNT, 0);

        for (int i = 0; i < 250; i++) begin
            ra = N'($urandom);
            case ($urandom_range(0, 2))
                0: rb = N'($urandom);
                1: rb = ~ra ^ N'(1 << $urandom_range(0, N - 1));
                default: rb = ~ra + N'($urandom_range(0, 2));
            endcase
            if ($urandom_range(0, 7) == 0) begin
                @(negedge CLK);
                CNT_CLR = 1'b1;
                @(negedge CLK);
                CNT_CLR = 1'b0;
            end
            run_txn(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b0,
                    s, ap, c, f, e, lat);
        end

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
